// File: rtl/control_entrada_operandos.sv
// control_entrada_operandos: debouncer tick, key edge detection and operand capture/handoff for the multiplier
//   clk        system clock
//   reset      asynchronous active-high reset
//   botones_db debounced buttons: [15]=ENTER, [14]=CLEAR, [N_BITS-1:0]=bit toggles
//   enable_db  one-cycle sample tick every TICK_DIV cycles
//   op_a/op_b  operands under construction, held while offered
//   op_valid   operand pair offered to the multiplier, op_ready accepts it
//   estado     00 CAP_A, 01 CAP_B, 10 ENVIA
//   error      one-cycle idle-timeout pulse in CAP_B, only when ENTRADA_TIMEOUT_EN is defined
module control_entrada_operandos #(
    parameter int TICK_DIV      = 100000,
    parameter int N_BITS        = 8,
    parameter int TIMEOUT_TICKS = 5000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [15:0]       botones_db,
    output logic              enable_db,
    output logic [N_BITS-1:0] op_a,
    output logic [N_BITS-1:0] op_b,
    output logic              op_valid,
    input  logic              op_ready,
    output logic [1:0]        estado,
    output logic              error
);
    localparam int CW = $clog2(TICK_DIV);
    typedef enum logic [1:0] {CAP_A = 2'b00, CAP_B = 2'b01, ENVIA = 2'b10} state_t;
    state_t            r_state;
    logic [CW-1:0]     r_cnt;
    logic [15:0]       r_prev;
    logic [15:0]       w_edge;
    logic              w_clr;
    logic              w_ent;
    logic [N_BITS-1:0] w_mask;
    logic              w_unused;
    assign estado    = r_state;
    assign enable_db = r_cnt == CW'(TICK_DIV - 1);
    assign w_edge    = botones_db & ~r_prev;
    assign w_clr     = w_edge[14];
    assign w_ent     = w_edge[15];
    assign w_mask    = w_edge[N_BITS-1:0];
    assign w_unused  = ^w_edge;
    always_ff @(posedge clk or posedge reset)
        if (reset) r_cnt <= '0;
        else       r_cnt <= enable_db ? '0 : r_cnt + 1'b1;
`ifdef ENTRADA_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_TICKS + 1);
    logic [TW-1:0] r_idle;
`else
    assign error = 1'b0;
`endif
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= CAP_A;
            op_a     <= '0;
            op_b     <= '0;
            op_valid <= 1'b0;
            r_prev   <= 16'hFFFF;
`ifdef ENTRADA_TIMEOUT_EN
            r_idle   <= '0;
            error    <= 1'b0;
`endif
        end else begin
            r_prev <= botones_db;
`ifdef ENTRADA_TIMEOUT_EN
            error  <= 1'b0;
`endif
            case (r_state)
                CAP_A:
                    if (w_clr) op_a <= '0;
                    else if (w_ent) begin
                        r_state <= CAP_B;
`ifdef ENTRADA_TIMEOUT_EN
                        r_idle  <= '0;
`endif
                    end else op_a <= op_a ^ w_mask;
                CAP_B:
                    if (w_clr) begin
                        op_a    <= '0;
                        op_b    <= '0;
                        r_state <= CAP_A;
                    end else if (w_ent) begin
                        r_state  <= ENVIA;
                        op_valid <= 1'b1;
                    end else begin
                        op_b <= op_b ^ w_mask;
`ifdef ENTRADA_TIMEOUT_EN
                        // a key edge restarts the idle count and wins over a coincident timeout
                        if (|w_mask) r_idle <= '0;
                        else if (enable_db) begin
                            if (r_idle == TW'(TIMEOUT_TICKS - 1)) begin
                                error   <= 1'b1;
                                op_a    <= '0;
                                op_b    <= '0;
                                r_state <= CAP_A;
                                r_idle  <= '0;
                            end else r_idle <= r_idle + 1'b1;
                        end
`endif
                    end
                default:
                    if (op_ready) begin
                        op_valid <= 1'b0;
                        op_a     <= '0;
                        op_b     <= '0;
                        r_state  <= CAP_A;
                    end
            endcase
        end
    end
endmodule
